// File: rtl/vec_accumulator_pkg.sv
// ----------------------------------------------------------------------------
// vec_accumulator_pkg
//   Shared definitions for the vector accumulator slice.
//   - acc_state_t : control states (ACCUM collects beats, HOLD presents a result)
//   - clog2       : constant-friendly ceiling log2, used to size the lane sum
// ----------------------------------------------------------------------------
package vec_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    // Number of extra bits needed so that the sum of 'value' operands cannot
    // overflow; clog2(1) is 0, so a single lane keeps its native width.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/vec_accumulator_if.sv
// ----------------------------------------------------------------------------
// vec_accumulator_if
//   Beat input and result output handshakes of the vector accumulator.
//   master : operand source + result consumer side
//   slave  : accumulator side
//   in_valid/in_ready/in_data/in_last : beat channel, lane i at [i*IN_W +: IN_W]
//   out_valid/out_ready/out_data/out_ovf : result channel, out_ovf is sticky
// ----------------------------------------------------------------------------
interface vec_accumulator_if #(
    parameter int LANES = 4,
    parameter int IN_W  = 8,
    parameter int ACC_W = 12
);

    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_data;
    logic                   out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );

endinterface

// File: rtl/vec_accumulator_lane_sum_tree.sv
// ----------------------------------------------------------------------------
// lane_sum_tree
//   Combinational reduction of LANES operands of IN_W bits into one sum of
//   IN_W+clog2(LANES) bits. Operands are sign-extended when SIGNED=1, else
//   zero-extended. The output width is exact, so the sum never overflows.
//   lanes : packed operands, lane i at [i*IN_W +: IN_W]
//   sum   : reduced result
// ----------------------------------------------------------------------------
module lane_sum_tree
    import vec_accumulator_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int IN_W   = 8,
    parameter int SIGNED = 0,
    parameter int SUM_W  = IN_W + clog2(LANES)
) (
    input  logic [LANES*IN_W-1:0] lanes,
    output logic [SUM_W-1:0]      sum
);

    logic [IN_W-1:0] lane;

    // Linear accumulation over the lanes; synthesis rebalances this into an
    // adder tree, and every lane is widened to the full sum width first.
    always_comb begin
        sum  = '0;
        lane = '0;
        for (int i = 0; i < LANES; i++) begin
            lane = lanes[i*IN_W +: IN_W];
            if (SIGNED != 0)
                sum = sum + SUM_W'($signed(lane));
            else
                sum = sum + SUM_W'(lane);
        end
    end

endmodule

// File: rtl/vec_accumulator.sv
// ----------------------------------------------------------------------------
// vec_accumulator
//   Two-stage pipelined multi-lane accumulator. Stage 1 registers the lane sum
//   of each accepted beat; stage 2 adds it into the ACC_W accumulator with
//   optional saturation. A beat flagged last closes the vector and the result
//   is held on the output handshake until consumed.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of vec_accumulator_if (beat in, result out)
// ----------------------------------------------------------------------------
module vec_accumulator
    import vec_accumulator_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int IN_W     = 8,
    parameter int ACC_W    = 12,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input logic              clk,
    input logic              rst,
    vec_accumulator_if.slave bus
);

    localparam int SUM_W = IN_W + clog2(LANES);
    localparam int EXT_W = ACC_W + 2;

    // Representable range of the accumulator, widened so the exact sum of
    // accumulator and lane sum can be compared against it without wrapping.
    localparam logic signed [EXT_W-1:0] HI_BOUND = (SIGNED != 0) ?
        {3'b000, {(ACC_W-1){1'b1}}} : {2'b00, {ACC_W{1'b1}}};
    localparam logic signed [EXT_W-1:0] LO_BOUND = (SIGNED != 0) ?
        {3'b111, {(ACC_W-1){1'b0}}} : {EXT_W{1'b0}};

    acc_state_t              state;
    acc_state_t              next_state;
    logic                    ready_en;
    logic                    accept;
    logic [SUM_W-1:0]        tree_sum;
    logic [SUM_W-1:0]        s1_sum;
    logic                    s1_vld;
    logic                    s1_last;
    logic [ACC_W-1:0]        acc;
    logic                    ovf_sticky;
    logic signed [EXT_W-1:0] acc_ext;
    logic signed [EXT_W-1:0] add_ext;
    logic signed [EXT_W-1:0] exact_sum;
    logic                    hi_ovf;
    logic                    lo_ovf;
    logic [ACC_W-1:0]        acc_next;
    logic                    out_take;

    lane_sum_tree #(
        .LANES  (LANES),
        .IN_W   (IN_W),
        .SIGNED (SIGNED),
        .SUM_W  (SUM_W)
    ) u_lane_sum_tree (
        .lanes (bus.in_data),
        .sum   (tree_sum)
    );

    // ready_en keeps in_ready low until the first edge after reset release;
    // the last-beat term stops a new beat sneaking in behind the closing one
    // before the FSM has moved to HOLD.
    assign bus.in_ready  = ready_en & (state == ACCUM) & ~(s1_vld & s1_last);
    assign accept        = bus.in_valid & bus.in_ready;
    assign out_take      = (state == HOLD) & bus.out_ready;
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = acc;
    assign bus.out_ovf   = ovf_sticky;

    // Exact accumulator update, then clamp or wrap depending on SATURATE.
    always_comb begin
        if (SIGNED != 0) begin
            acc_ext = EXT_W'($signed(acc));
            add_ext = EXT_W'($signed(s1_sum));
        end else begin
            acc_ext = EXT_W'(acc);
            add_ext = EXT_W'(s1_sum);
        end
        exact_sum = acc_ext + add_ext;
        hi_ovf    = exact_sum > HI_BOUND;
        lo_ovf    = exact_sum < LO_BOUND;
        acc_next  = exact_sum[ACC_W-1:0];
        if (SATURATE != 0) begin
            if (hi_ovf)
                acc_next = HI_BOUND[ACC_W-1:0];
            else if (lo_ovf)
                acc_next = LO_BOUND[ACC_W-1:0];
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ACCUM;
        else
            state <= next_state;
    end

    // Close the vector when the last beat reaches stage 2; reopen on handshake.
    always_comb begin
        next_state = state;
        case (state)
            ACCUM:   if (s1_vld & s1_last) next_state = HOLD;
            HOLD:    if (bus.out_ready)    next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    // Stage-1 register and stage-2 accumulator. The accumulator doubles as
    // the result register, so it only changes in ACCUM or on the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en   <= 1'b0;
            s1_sum     <= '0;
            s1_vld     <= 1'b0;
            s1_last    <= 1'b0;
            acc        <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            s1_vld   <= accept;
            s1_last  <= accept & bus.in_last;
            if (accept)
                s1_sum <= tree_sum;
            if (out_take) begin
                acc        <= '0;
                ovf_sticky <= 1'b0;
            end else if ((state == ACCUM) && s1_vld) begin
                acc        <= acc_next;
                ovf_sticky <= ovf_sticky | hi_ovf | lo_ovf;
            end
        end
    end

endmodule
